// File: rtl/if_fetch_unit_pkg.sv
// Shared IF-stage widths, reset PC and the IF/ID bundle.
// Imported by the fetch unit, its skid entry and the ROM interface.
package if_fetch_unit_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = '0;
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
  localparam logic [INST_W-1:0] NOP      = '0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } if_id_t;

  localparam if_id_t BUBBLE = '{
    valid: 1'b0,
    pc:    '0,
    inst:  NOP
  };

  function automatic logic [ADDR_W-1:0] next_pc(
    input logic [ADDR_W-1:0] pc
  );
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction ROM request/response bus.
// master = fetch unit, slave = ROM.
interface if_fetch_unit_if;
  import if_fetch_unit_pkg::*;

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ready;
  logic              rvalid;
  logic [INST_W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/if_fetch_unit_skid.sv
// One-entry skid register holding a fetched pc/inst pair.
// load wins over clr so a drain and refill can share one edge.
module if_skid_buf
  import if_fetch_unit_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   clr,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t ent_d;
  if_id_t ent_q;

  always_comb begin
    ent_d = ent_q;
    if (load) begin
      ent_d = d;
    end else if (clr) begin
      ent_d = BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q <= BUBBLE;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign q = ent_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding ROM request,
// IF/ID output register with skid entry and branch squash.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  if_fetch_unit_if.master   rom,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              if_valid
);

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_pc_d;
  logic [ADDR_W-1:0] req_pc_q;
  logic              outstanding_d;
  logic              outstanding_q;
  logic              drop_d;
  logic              drop_q;
  if_id_t            out_d;
  if_id_t            out_q;

  if_id_t            skid_q;
  if_id_t            rsp;
  logic              skid_load;
  logic              skid_clr;

  logic              req_acc;
  logic              rsp_hit;
  logic              rsp_keep;
  logic              take;
  logic              hold;

  // rst gates the request so nothing leaks out while reset is held
  assign rom.req  = rst & ~outstanding_q & ~skid_q.valid;
  assign rom.addr = pc_q;

  assign req_acc  = rom.req & rom.ready;
  assign rsp_hit  = outstanding_q & rom.rvalid;
  assign rsp_keep = rsp_hit & ~drop_q;

  assign rsp = '{
    valid: 1'b1,
    pc:    req_pc_q,
    inst:  rom.rdata
  };

  always_comb begin
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;

    if (req_acc) begin
      outstanding_d = 1'b1;
      req_pc_d      = pc_q;
      pc_d          = next_pc(pc_q);
    end else if (rsp_hit) begin
      outstanding_d = 1'b0;
      drop_d        = 1'b0;
    end

    // in-flight or just-issued request belongs to the old path
    if (branch_taken) begin
      pc_d   = branch_target;
      drop_d = (outstanding_q & ~rom.rvalid) | req_acc;
    end
  end

  assign take = ~branch_taken & (~stall | ~out_q.valid);
  assign hold = ~branch_taken & stall & out_q.valid;

  always_comb begin
    out_d     = out_q;
    skid_load = 1'b0;
    skid_clr  = 1'b0;

    unique case (1'b1)
      branch_taken: begin
        out_d    = BUBBLE;
        skid_clr = 1'b1;
      end
      take: begin
        if (skid_q.valid) begin
          out_d     = skid_q;
          skid_load = rsp_keep;
          skid_clr  = 1'b1;
        end else if (rsp_keep) begin
          out_d = rsp;
        end else begin
          out_d = BUBBLE;
        end
      end
      hold: begin
        skid_load = rsp_keep;
      end
      default: begin
        out_d = out_q;
      end
    endcase
  end

  if_skid_buf u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .clr  (skid_clr),
    .d    (rsp),
    .q    (skid_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      out_q         <= BUBBLE;
    end else begin
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      out_q         <= out_d;
    end
  end

  assign if_pc    = out_q.pc;
  assign if_inst  = out_q.inst;
  assign if_valid = out_q.valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus
// random stall/branch/latency against a program-order model.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic              clk = 1'b0;
  logic              clk_en = 1'b1;
  logic              rst = 1'b0;
  logic              stall = 1'b0;
  logic              branch_taken = 1'b0;
  logic [ADDR_W-1:0] branch_target = '0;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_valid;

  if_fetch_unit_if rom_bus ();

  if_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .rom           (rom_bus),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .if_valid      (if_valid)
  );

  always #5 if (clk_en) clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_pc;
  bit          pend;
  logic [31:0] paddr;
  int          cnt;
  int          lat_fix = -1;
  bit          stray;
  int          consumed;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'h5A3C_9601;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_lat();
    if (lat_fix >= 0) return lat_fix;
    case ($urandom_range(0, 3))
      0: return 0;
      1: return 2;
      2: return 7;
      default: return int'($urandom_range(0, 4));
    endcase
  endfunction

  // one cycle: called at a falling edge with inputs already chosen
  task automatic step();
    bit          resp_now;
    bit          acc;
    logic [31:0] acc_addr;
    #1;
    resp_now = 1'b0;
    if (pend && cnt == 0) begin
      resp_now       = 1'b1;
      rom_bus.rvalid = 1'b1;
      rom_bus.rdata  = rom_word(paddr);
    end else begin
      rom_bus.rvalid = stray;
      rom_bus.rdata  = stray ? 32'hDEAD_BEEF : $urandom;
      if (pend) cnt--;
    end
    acc      = rom_bus.req && rom_bus.ready;
    acc_addr = rom_bus.addr;
    if (pend) chk("one_outstanding", 32'(rom_bus.req), 32'd0);
    if (!if_valid) begin
      chk("bubble_pc", if_pc, 32'd0);
      chk("bubble_inst", if_inst, 32'd0);
    end
    if (!branch_taken && !stall && if_valid) begin
      chk("seq_pc", if_pc, exp_pc);
      chk("seq_inst", if_inst, rom_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    if (branch_taken) exp_pc = branch_target;
    @(posedge clk);
    if (resp_now) pend = 1'b0;
    if (acc) begin
      pend  = 1'b1;
      paddr = acc_addr;
      cnt   = pick_lat();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    stall          = 1'b0;
    branch_taken   = 1'b0;
    rom_bus.ready  = 1'b0;
    rom_bus.rvalid = 1'b0;
    rom_bus.rdata  = '0;
    stray          = 1'b0;
    pend           = 1'b0;
    exp_pc         = RESET_PC;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    chk("rst_req", 32'(rom_bus.req), 32'd0);
    rst = 1'b1;
    #1;
  endtask

  task automatic wait_present(input logic [31:0] a);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (if_valid && if_pc == a) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("reach_pc", 32'(ok), 32'd1);
  endtask

  // after a redirect: first request and first real output hit tgt
  task automatic expect_redirect(input logic [31:0] tgt);
    bit seen;
    bit ok;
    seen = 1'b0;
    ok   = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rom_bus.req && !seen) begin
        chk("redir_addr", rom_bus.addr, tgt);
        seen = 1'b1;
      end
      if (if_valid) begin
        chk("redir_pc", if_pc, tgt);
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("redir_reached", 32'(ok), 32'd1);
  endtask

  task automatic br_on_accept(input logic stall_v);
    do_reset();
    rom_bus.ready = 1'b1;
    lat_fix       = 0;
    wait_present(32'h2C);
    chk("pre_br_addr", rom_bus.addr, 32'h30);
    chk("pre_br_req", 32'(rom_bus.req), 32'd1);
    stall         = stall_v;
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    step();
    branch_taken = 1'b0;
    stall        = 1'b0;
    chk("flush_valid", 32'(if_valid), 32'd0);
    chk("flush_pc", if_pc, 32'd0);
    chk("flush_inst", if_inst, 32'd0);
    expect_redirect(32'h200);
  endtask

  localparam bit   T1_REQ [7] = '{1, 0, 1, 0, 1, 0, 1};
  localparam int   T1_ADDR[7] = '{0, 0, 4, 0, 8, 0, 12};
  localparam bit   T1_VAL [7] = '{0, 0, 1, 0, 1, 0, 1};
  localparam int   T1_PC  [7] = '{0, 0, 0, 0, 4, 0, 8};

  initial begin
    consumed = 0;
    @(negedge clk);

    // back-to-back fetch with a 1-cycle ROM
    do_reset();
    rom_bus.ready = 1'b1;
    lat_fix       = 0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("t1_req%0d", k), 32'(rom_bus.req), 32'(T1_REQ[k]));
      if (T1_REQ[k])
        chk($sformatf("t1_addr%0d", k), rom_bus.addr, 32'(T1_ADDR[k]));
      chk($sformatf("t1_val%0d", k), 32'(if_valid), 32'(T1_VAL[k]));
      chk($sformatf("t1_pc%0d", k), if_pc, 32'(T1_PC[k]));
      step();
    end

    // stall with a response landing in the skid entry
    wait_present(32'h24);
    chk("t2_req_addr", rom_bus.addr, 32'h28);
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t2_hold_pc", if_pc, 32'h24);
      chk("t2_hold_val", 32'(if_valid), 32'd1);
      chk("t2_hold_req", 32'(rom_bus.req), 32'd0);
    end
    stall = 1'b0;
    step();
    chk("t2_skid_pc", if_pc, 32'h28);
    chk("t2_skid_val", 32'(if_valid), 32'd1);
    chk("t2_next_req", 32'(rom_bus.req), 32'd1);
    chk("t2_next_addr", rom_bus.addr, 32'h2C);

    // branch while a slow request is in flight
    do_reset();
    branch_taken  = 1'b1;
    branch_target = 32'h10;
    step();
    branch_taken  = 1'b0;
    rom_bus.ready = 1'b1;
    lat_fix       = 3;
    chk("t3_addr", rom_bus.addr, 32'h10);
    step();
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    step();
    branch_taken = 1'b0;
    expect_redirect(32'h100);

    // branch in the cycle the old-path request is accepted
    br_on_accept(1'b0);
    br_on_accept(1'b1);

    // random stall, branch, ready and latency
    do_reset();
    lat_fix  = -1;
    consumed = 0;
    for (int i = 0; i < 3000; i++) begin
      stall         = ($urandom_range(0, 9) < 4);
      branch_taken  = ($urandom_range(0, 24) == 0);
      branch_target = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0
                    : {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
      rom_bus.ready = ($urandom_range(0, 9) < 7);
      step();
    end
    stall         = 1'b0;
    branch_taken  = 1'b0;
    rom_bus.ready = 1'b1;
    repeat (30) step();
    chk("rand_progress", 32'(consumed >= 100), 32'd1);

    // async reset while the clock is stopped, then a stray rvalid
    do_reset();
    rom_bus.ready = 1'b1;
    lat_fix       = 0;
    wait_present(32'h4);
    lat_fix = 7;
    stall   = 1'b1;
    step();
    chk("t6_pre_val", 32'(if_valid), 32'd1);
    clk_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_val", 32'(if_valid), 32'd0);
    chk("t6_rst_pc", if_pc, 32'd0);
    chk("t6_rst_inst", if_inst, 32'd0);
    chk("t6_rst_req", 32'(rom_bus.req), 32'd0);
    rst           = 1'b1;
    pend          = 1'b0;
    exp_pc        = RESET_PC;
    stall         = 1'b0;
    rom_bus.ready = 1'b0;
    #1;
    chk("t6_rel_req", 32'(rom_bus.req), 32'd1);
    chk("t6_rel_addr", rom_bus.addr, RESET_PC);
    clk_en = 1'b1;
    stray  = 1'b1;
    step();
    stray = 1'b0;
    chk("t6_stray_val", 32'(if_valid), 32'd0);
    step();
    chk("t6_stray_val2", 32'(if_valid), 32'd0);
    chk("t6_stray_addr", rom_bus.addr, RESET_PC);
    rom_bus.ready = 1'b1;
    lat_fix       = 0;
    consumed      = 0;
    repeat (12) step();
    chk("t6_progress", 32'(consumed >= 3), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage: owns the PC, issues requests to the instruction ROM, and drives the if_pc/if_inst pair captured by the IF/ID pipeline register.
- Tolerates variable ROM latency through a request/response handshake.
- Holds fetched instructions while ID stalls, using the output register plus a 1-entry skid buffer.
- Redirects the PC and squashes in-flight work on a taken branch.

Parameters:
ADDR_W, 32, instruction address width
INST_W, 32, instruction width
RESET_PC, 0, PC value after reset
PC_STEP, 4, PC increment per sequential fetch

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low (asserted at 0)
stall  in  1  ID not accepting; IF/ID holds its contents
branch_taken  in  1  taken-branch redirect from ID
branch_target  in  ADDR_W  redirect address
rom_req  out  1  request valid to ROM
rom_addr  out  ADDR_W  request address
rom_ready  in  1  ROM accepts request this cycle
rom_rvalid  in  1  response data valid this cycle
rom_rdata  in  INST_W  response instruction
if_pc  out  ADDR_W  PC of presented instruction (0 when bubble)
if_inst  out  INST_W  presented instruction (0 = NOP bubble)
if_valid  out  1  presented instruction is real

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC.
  - if_pc=0, if_inst=0, if_valid=0.
  - skid empty; outstanding=0; drop=0.
  - rom_req=0 (combinational terms are masked while in reset).
- Request issue:
  - rom_req = !outstanding && !skid_valid; rom_addr = pc.
  - A request is accepted on a clock edge with rom_req && rom_ready. At that edge: outstanding<=1, req_pc<=pc, pc<=pc+PC_STEP (mod 2^ADDR_W, wraps silently).
  - At most one request is outstanding, so the peak rate is one fetch per 2 cycles with a 1-cycle ROM. A new request is never issued in the same cycle as a response.
- Response:
  - An edge with outstanding && rom_rvalid clears outstanding.
  - If drop=1, the data is discarded and drop<=0.
  - Otherwise the response is {req_pc, rom_rdata} and is steered per the output rules below.
  - rom_rvalid with outstanding=0 is ignored (protocol error, no state change).
- Output register update at each edge, in priority order:
  1. branch_taken: if_* <= 0 and if_valid <= 0; skid emptied; pc <= branch_target. drop <= 1 if a request is outstanding and its response is not arriving this cycle, or if a request is being accepted this cycle (that request targets the old pc). Branch overrides stall.
  2. !stall || !if_valid:
     - If skid is valid: out <= skid; skid <= the response if one arrives this cycle, else empty.
     - Else if a response arrives: out <= the response.
     - Else: out <= bubble (0/0/0).
  3. stall && if_valid: out holds. An arriving response is written to skid; skid is guaranteed empty by the request gating.
- Latency: ROM response at edge N means the instruction appears on if_* after edge N if the output is free.
- Branch and rom_ready on the same cycle: the old-pc request is accepted, marked drop, and pc becomes the target. The next request goes to the target after that response returns.
- Branch and rom_rvalid on the same cycle: the response is dropped and drop stays 0.
- Reset mid-transaction: all state is cleared. A ROM response arriving after reset release with outstanding=0 is ignored.
- Invariant: an instruction is never duplicated or lost while stall toggles. Every accepted non-dropped request reaches if_* exactly once.

Decomposition:
- Shared package/include: ADDR_W, INST_W, RESET_PC, PC_STEP, and the NOP/bubble constant (all zeros), so IF/ID and ID share them.
- One sub-module, if_skid_buf (1-entry valid+pc+inst register with load/clear), used for the skid entry.
- The PC/request/drop logic stays in the top module.

Test Plan:
- Reset release, ROM ready=1 with 1-cycle rvalid, stall=0 -> rom_addr 0,4,8 on alternate cycles; if_pc 0,4,8 with if_valid pulses. if_pc/if_inst are 0 in the gaps.
- stall=1 held 5 cycles while if_valid=1 with 0x24 presented and a request to 0x28 outstanding -> 0x28 enters skid, rom_req=0, if_pc stays 0x24. After stall drops: 0x28 on the next edge, then 0x2C is fetched.
- Request to 0x10 accepted, branch_taken to 0x100 asserted the following cycle, rvalid returns 3 cycles later -> 0x10 data never appears on if_*; next rom_addr=0x100; if_valid=0 until 0x100 returns.
- branch_taken to 0x200 in the same cycle as rom_ready for 0x30 -> 0x30 response dropped; next request is 0x200. The same scenario with stall=1 still flushes if_* to 0.
- Variable latency: rvalid delayed 0, 2, 7 cycles with random stall -> the if_valid instruction sequence exactly equals the address sequence, with no duplicates or gaps.
- rst driven low mid-wait (outstanding=1) while clk is stopped -> outputs go to 0 immediately. After release: rom_addr=RESET_PC, and a stray rvalid is ignored.
